wide_add_sequencer: RTL
=======================

Name: wide_add_sequencer

Overview:
- Multi-cycle controller that computes an N*K-bit add or subtract using one shared N-bit ripple_adder instance, one N-bit slice per clock.
- Registers the carry between slices.
- Sits between a requester and a consumer, with valid/ready handshakes on both sides.
- Lets wide arithmetic reuse the narrow ripple datapath instead of instantiating an N*K-bit adder.

Parameters:
- N, 4, slice width; width of the internal ripple_adder instance.
- K, 4, number of slices; operand width W = N*K; K >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  N*K  operand A, captured on accept.
- b  input  N*K  operand B, captured on accept.
- ci  input  1  carry-in for add, captured on accept; ignored for subtract.
- sub  input  1  1 = A - B, 0 = A + B + ci; captured on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  N*K  result.
- co  output  1  final carry-out. For subtract, co = 1 means no borrow (A >= B unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1), takes effect immediately and holds while rst is high:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - sum = 0; co = 0; slice index = 0; carry register = 0; operand registers = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: capture a into A_reg.
  - Capture b into B_reg, or ~b when sub = 1.
  - Load the carry register with ci when sub = 0, or 1 when sub = 1.
  - Set idx = 0, clear sum, go to RUN.
- RUN:
  - in_ready = 0.
  - Adder inputs each cycle: A_reg and B_reg slice [idx*N +: N], carry-in = carry register.
  - At each edge: write the adder S into sum[idx*N +: N], load the adder c0 into the carry register, idx++.
  - When idx == K-1 at the edge: also load co from adder c0 and go to DONE.
- Latency: out_valid rises exactly K clock edges after the accepting edge.
  - Example: K=4, accept at edge 0, out_valid=1 after edge 4.
- DONE:
  - out_valid = 1; sum and co are held stable.
  - On out_valid & out_ready: go to IDLE, clear out_valid.
  - in_ready becomes 1 in the next cycle; there is no overlap of accept and deliver.
  - Peak throughput: one operation per K+2 cycles when out_ready is held high.
- Backpressure: out_ready low in DONE holds state, sum and co indefinitely.
- Operands: a, b, ci and sub are sampled only on the accepting edge. Later changes have no effect on the operation in flight.
- Widths: sum wraps modulo 2^(N*K); co carries the overflow bit. No signed interpretation is applied inside the block.
- sub = 1 ignores ci (two's-complement subtract).
- K = 1: RUN lasts one cycle and behaves like a registered single adder.
- in_valid asserted outside IDLE is ignored; the request stays pending under the requester's valid/ready rules.
- Reset mid-RUN or mid-DONE: the result is discarded with no out_valid pulse, and the block returns to IDLE values asynchronously.
- sum/co are only meaningful while out_valid = 1. Intermediate slice updates during RUN are visible but carry no meaning.
- The datapath is always the ripple_adder (full_adder chain). The controller adds no arithmetic of its own beyond the B inversion and the carry mux.

Test Plan (N=4, K=4):
- Basic add: a=0x00FF, b=0x0001, ci=0, sub=0, out_ready=1.
  - Required: out_valid exactly 4 edges after accept; sum=0x0100, co=0; in_ready back to 1 one cycle after the deliver handshake.
- Full carry ripple across all slices: a=0xFFFF, b=0x0000, ci=1.
  - Required: sum=0x0000, co=1.
- Overflow add: a=0x8001, b=0x8001, ci=0.
  - Required: sum=0x0002, co=1.
- Subtract with borrow: a=0x1234, b=0x1235, sub=1, ci=1 (must be ignored).
  - Required: sum=0xFFFF, co=0.
- Subtract without borrow: a=0x1235, b=0x1234, sub=1.
  - Required: sum=0x0001, co=1.
- Backpressure and operand isolation:
  - Hold out_ready=0 for 10 cycles in DONE, and change a/b during RUN.
  - Required: sum/co unchanged and out_valid held; a new in_valid is not accepted (in_ready=0) until out_ready=1.
- Reset mid-RUN: assert rst asynchronously two cycles after accept.
  - Required: out_valid=0, sum=0, co=0 and in_ready=1 immediately.
  - Required: the next request (0x0003+0x0004) returns sum=0x0007, co=0 with normal latency.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: computes an N*K-bit add or subtract one N-bit slice
// per clock, reusing a single N-bit ripple_adder and registering the carry
// between slices. Valid/ready handshakes on the request and result sides.

// One-bit full adder cell used by the ripple chain.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

// N-bit ripple-carry adder built from a chain of full_adder cells.
module ripple_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  // carry[i] feeds bit i; carry[N] is the carry out of the top bit
  logic [N:0] carry;

  assign carry[0] = ci;
  assign co       = carry[N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      full_adder u_fa (
        .x    (a[gi]),
        .y    (b[gi]),
        .cin  (carry[gi]),
        .s    (s[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate
endmodule

// Slice-serial wide adder controller.
module wide_add_sequencer #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           ci,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] sum,
  output logic           co,
  output logic           busy
);
  localparam int W  = N * K;
  // Slice index needs at least one bit even when K = 1
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;      // already inverted for subtract
  logic            carry_reg;
  logic [IW-1:0]   idx;

  // Per-slice views of the captured operands, selected by idx
  logic [N-1:0]    a_slice [K];
  logic [N-1:0]    b_slice [K];
  logic [N-1:0]    adder_a;
  logic [N-1:0]    adder_b;
  logic [N-1:0]    adder_s;
  logic            adder_co;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*N +: N];
      assign b_slice[gi] = b_reg[gi*N +: N];
    end
  endgenerate

  // Steer the active slice onto the shared adder inputs
  always_comb begin
    adder_a = '0;
    adder_b = '0;
    for (int s = 0; s < K; s++) begin
      if (idx == IW'(s)) begin
        adder_a = a_slice[s];
        adder_b = b_slice[s];
      end
    end
  end

  ripple_adder #(.N(N)) u_adder (
    .a  (adder_a),
    .b  (adder_b),
    .ci (carry_reg),
    .s  (adder_s),
    .co (adder_co)
  );

  // Controller FSM with registered handshake outputs and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          if (in_valid && in_ready) begin
            // Subtract is A + ~B + 1, so ci is ignored in that mode
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : ci;
            idx       <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          for (int s = 0; s < K; s++) begin
            if (idx == IW'(s)) begin
              sum[s*N +: N] <= adder_s;
            end
          end
          carry_reg <= adder_co;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            co        <= adder_co;
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Result and co hold until the consumer takes them
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
